// File: rtl/riscv_pkg.sv
// Shared types for the load/store path: FSM states, access sizes, byte-enable patterns.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WB    = 2'd2,
        FAULT = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Byte lanes touched by an access of size sz at byte offset off.
    function automatic logic [3:0] lsu_be(input lsu_size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = BE_BYTE0 << off;
            SZ_H:    be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/riscv_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module riscv_load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  lsu_size_e   size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension; words pass straight through.
    always_comb begin
        byte_sel = rdata_i[7:0];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (size_i)
            SZ_B:    data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            SZ_H:    data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Single-outstanding load/store unit: decodes the op, drives the data-memory
// handshake with a timeout, and returns extended load data to writeback.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic        is_lb,
    input  logic        is_lh,
    input  logic        is_lw,
    input  logic        is_lbu,
    input  logic        is_lhu,
    input  logic        is_sb,
    input  logic        is_sh,
    input  logic        is_sw,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    // +1 keeps the counter at least one bit wide when TIMEOUT_CYCLES is 1.
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Captured op, held for the whole transaction.
    lsu_size_e  size_q, size_d;
    logic       uns_q, uns_d;
    logic [1:0] off_q, off_d;
    logic [4:0] rd_q, rd_d;

    // Registered outputs.
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wbv_q, wbv_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        mis_q, mis_d;
    logic        to_q, to_d;

    // Decode of the presented op.
    logic        any_flag;
    lsu_size_e   dec_size;
    logic        dec_uns;
    logic        dec_we;
    logic        dec_mis;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [31:0] ext_data;

    riscv_load_extend u_ext (
        .rdata_i (mem_rdata_i),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (ext_data)
    );

    assign any_flag = is_lb | is_lh | is_lw | is_lbu | is_lhu | is_sb | is_sh | is_sw;

    // Priority decode when several flags are set: lw > lh > lhu > lb > lbu > sw > sh > sb.
    always_comb begin
        dec_size = SZ_W;
        dec_uns  = 1'b0;
        dec_we   = 1'b0;
        if (is_lw) begin
            dec_size = SZ_W;
        end else if (is_lh) begin
            dec_size = SZ_H;
        end else if (is_lhu) begin
            dec_size = SZ_H;
            dec_uns  = 1'b1;
        end else if (is_lb) begin
            dec_size = SZ_B;
        end else if (is_lbu) begin
            dec_size = SZ_B;
            dec_uns  = 1'b1;
        end else if (is_sw) begin
            dec_size = SZ_W;
            dec_we   = 1'b1;
        end else if (is_sh) begin
            dec_size = SZ_H;
            dec_we   = 1'b1;
        end else if (is_sb) begin
            dec_size = SZ_B;
            dec_we   = 1'b1;
        end
    end

    // Alignment check, byte enables and lane-replicated store data.
    always_comb begin
        case (dec_size)
            SZ_H:    dec_mis = addr_i[0];
            SZ_W:    dec_mis = |addr_i[1:0];
            default: dec_mis = 1'b0;
        endcase
        dec_be    = lsu_be(dec_size, addr_i[1:0]);
        dec_wdata = 32'd0;
        if (dec_we) begin
            case (dec_size)
                SZ_B:    dec_wdata = {4{wdata_i[7:0]}};
                SZ_H:    dec_wdata = {2{wdata_i[15:0]}};
                default: dec_wdata = wdata_i;
            endcase
        end
    end

    assign op_ready_o = (state_q == IDLE);

    // Next state plus next values of every registered output; bus outputs return to zero outside REQ.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        rd_d     = rd_q;
        req_d    = 1'b0;
        we_d     = 1'b0;
        maddr_d  = 32'd0;
        be_d     = BE_NONE;
        wdata_d  = 32'd0;
        wbv_d    = 1'b0;
        wbrd_d   = wbrd_q;
        wbdata_d = wbdata_q;
        mis_d    = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid_i && any_flag) begin
                    size_d = dec_size;
                    uns_d  = dec_uns;
                    off_d  = addr_i[1:0];
                    rd_d   = rd_i;
                    if (dec_mis) begin
                        state_d = FAULT;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = dec_we;
                        maddr_d = {addr_i[31:2], 2'b00};
                        be_d    = dec_be;
                        wdata_d = dec_wdata;
                    end
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = WB;
                        wbv_d    = 1'b1;
                        wbrd_d   = rd_q;
                        wbdata_d = ext_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    req_d   = 1'b1;
                    we_d    = we_q;
                    maddr_d = maddr_q;
                    be_d    = be_q;
                    wdata_d = wdata_q;
                end
            end
            WB:      state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Counter, captured op and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            off_q    <= 2'd0;
            rd_q     <= 5'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= 32'd0;
            be_q     <= BE_NONE;
            wdata_q  <= 32'd0;
            wbv_q    <= 1'b0;
            wbrd_q   <= 5'd0;
            wbdata_q <= 32'd0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            wbv_q    <= wbv_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            mis_q    <= mis_d;
            to_q     <= to_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = maddr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign wb_valid_o  = wbv_q;
    assign wb_rd_o     = wbrd_q;
    assign wb_data_o   = wbdata_q;
    assign misalign_o  = mis_q;
    assign timeout_o   = to_q;

endmodule
